// File: rtl/bus_interface_pkg.sv
// Shared types and constants for the bus interface: response codes and the
// state sets of the handshake sequencer and the instruction/data views.
package bus_interface_pkg;

  localparam int BUS_RESP_WIDTH = 1;
  localparam logic [BUS_RESP_WIDTH-1:0] BUS_RESP_OK    = 1'b0;
  localparam logic [BUS_RESP_WIDTH-1:0] BUS_RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_RESP} hs_state_t;

  typedef enum logic [1:0] {I_IDLE, I_REQ, I_RESP} i_state_t;

  typedef enum logic [2:0] {
    D_IDLE, D_RD_REQ, D_RD_RESP, D_WR_REQ, D_WR_RESP
  } d_state_t;

endpackage

// File: rtl/bus_interface_if.sv
// External memory bus: instruction read, data read and data write channels.
// master = bus_interface side, slave = memory side.
interface bus_interface_if
  import bus_interface_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                      ir_addr_valid;
  logic                      ir_addr_ready;
  logic [ADDR_WIDTH-1:0]     ir_addr;
  logic                      ir_data_valid;
  logic                      ir_data_ready;
  logic [DATA_WIDTH-1:0]     ir_data;

  logic                      dr_addr_valid;
  logic                      dr_addr_ready;
  logic [ADDR_WIDTH-1:0]     dr_addr;
  logic                      dr_data_valid;
  logic                      dr_data_ready;
  logic [DATA_WIDTH-1:0]     dr_data;

  logic                      dw_data_addr_valid;
  logic                      dw_data_addr_ready;
  logic [ADDR_WIDTH-1:0]     dw_addr;
  logic [DATA_WIDTH-1:0]     dw_data;
  logic [DATA_WIDTH/8-1:0]   dw_strobe;
  logic                      dw_resp_valid;
  logic                      dw_resp_ready;
  logic [BUS_RESP_WIDTH-1:0] dw_resp;

  modport master (
    output ir_addr_valid, ir_addr, ir_data_ready,
    input  ir_addr_ready, ir_data_valid, ir_data,
    output dr_addr_valid, dr_addr, dr_data_ready,
    input  dr_addr_ready, dr_data_valid, dr_data,
    output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    input  dw_data_addr_ready, dw_resp_valid, dw_resp
  );

  modport slave (
    input  ir_addr_valid, ir_addr, ir_data_ready,
    output ir_addr_ready, ir_data_valid, ir_data,
    input  dr_addr_valid, dr_addr, dr_data_ready,
    output dr_addr_ready, dr_data_valid, dr_data,
    input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    output dw_data_addr_ready, dw_resp_valid, dw_resp
  );

endinterface

// File: rtl/bus_handshake.sv
// Generic request/response sequencer: start pulse -> request valid until
// ready -> response ready until valid -> one-cycle done pulse.
module bus_handshake
  import bus_interface_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  output logic      req_valid,
  input  logic      req_ready,
  input  logic      resp_valid,
  output logic      resp_ready,
  output logic      done,
  output hs_state_t state
);

  hs_state_t state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every process
  // sees the pre-edge value of state within the same clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HS_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == HS_RESP) && resp_valid;
    end
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      HS_IDLE: if (start)      state_nxt = HS_REQ;
      HS_REQ:  if (req_ready)  state_nxt = HS_RESP;
      HS_RESP: if (resp_valid) state_nxt = HS_IDLE;
      default:                 state_nxt = HS_IDLE;
    endcase
  end

  // Decoded straight from the state flops, so these behave as registered outputs.
  assign req_valid  = (state == HS_REQ);
  assign resp_ready = (state == HS_RESP);

endmodule

// File: rtl/bus_interface.sv
// Turns control-unit request pulses into valid/ready bus transactions and
// returns completion pulses with registered read data.
module bus_interface
  import bus_interface_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_fetch,
  input  logic [ADDR_WIDTH-1:0]   pc,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst,
  input  logic                    load_data,
  input  logic                    store_data,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    bus_error,
  bus_interface_if.master         bus
);

  hs_state_t i_hs, rd_hs, wr_hs;
  i_state_t  i_state;
  d_state_t  d_state;
  logic      i_start, rd_start, wr_start;
  logic      rd_done, wr_done;

  always_comb begin
    case (i_hs)
      HS_REQ:  i_state = I_REQ;
      HS_RESP: i_state = I_RESP;
      default: i_state = I_IDLE;
    endcase
    // The write path wins if both were ever busy; starts make that impossible.
    d_state = D_IDLE;
    if      (wr_hs == HS_REQ)  d_state = D_WR_REQ;
    else if (wr_hs == HS_RESP) d_state = D_WR_RESP;
    else if (rd_hs == HS_REQ)  d_state = D_RD_REQ;
    else if (rd_hs == HS_RESP) d_state = D_RD_RESP;
  end

  assign i_start  = inst_fetch && (i_state == I_IDLE);
  assign wr_start = store_data && (d_state == D_IDLE);
  assign rd_start = load_data && !store_data && (d_state == D_IDLE);

  bus_handshake u_ir (
    .clk, .rst, .start(i_start),
    .req_valid(bus.ir_addr_valid), .req_ready(bus.ir_addr_ready),
    .resp_valid(bus.ir_data_valid), .resp_ready(bus.ir_data_ready),
    .done(inst_valid), .state(i_hs)
  );

  bus_handshake u_dr (
    .clk, .rst, .start(rd_start),
    .req_valid(bus.dr_addr_valid), .req_ready(bus.dr_addr_ready),
    .resp_valid(bus.dr_data_valid), .resp_ready(bus.dr_data_ready),
    .done(rd_done), .state(rd_hs)
  );

  bus_handshake u_dw (
    .clk, .rst, .start(wr_start),
    .req_valid(bus.dw_data_addr_valid), .req_ready(bus.dw_data_addr_ready),
    .resp_valid(bus.dw_resp_valid), .resp_ready(bus.dw_resp_ready),
    .done(wr_done), .state(wr_hs)
  );

  // Only one data path is ever active, so the OR is the read/write mux.
  assign data_valid = rd_done | wr_done;

  // NOTE: the captured address/data registers are reset because they drive
  // the bus and control unit directly and must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.ir_addr <= '0;
      inst        <= '0;
    end else begin
      if (i_start) bus.ir_addr <= pc;
      if (bus.ir_data_valid && bus.ir_data_ready) inst <= bus.ir_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.dr_addr   <= '0;
      bus.dw_addr   <= '0;
      bus.dw_data   <= '0;
      bus.dw_strobe <= '0;
      rdata         <= '0;
      bus_error     <= 1'b0;
    end else begin
      if (rd_start) bus.dr_addr <= data_addr;
      if (wr_start) begin
        bus.dw_addr   <= data_addr;
        bus.dw_data   <= data_wdata;
        bus.dw_strobe <= data_wstrb;
      end
      if (bus.dr_data_valid && bus.dr_data_ready) rdata <= bus.dr_data;
      bus_error <= bus.dw_resp_valid && bus.dw_resp_ready
                   && (bus.dw_resp != BUS_RESP_OK);
    end
  end

endmodule

// File: tb/tb_bus_interface.sv
// Self-checking bench: bus slaves with randomized ready/response delays and a
// transaction-level model of expected addresses, latencies and pulse counts.
module tb_bus_interface;
  import bus_interface_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inst_fetch = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic          load_data = 1'b0;
  logic          store_data = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [SW-1:0] data_wstrb = '0;
  logic          data_valid;
  logic [DW-1:0] rdata;
  logic          bus_error;

  bus_interface_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_fetch(inst_fetch), .pc(pc), .inst_valid(inst_valid), .inst(inst),
    .load_data(load_data), .store_data(store_data), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_valid(data_valid), .rdata(rdata), .bus_error(bus_error),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level expectations
  int            exp_inst_n = 0, exp_data_n = 0, exp_err_n = 0;
  int            got_inst_n = 0, got_data_n = 0, got_err_n = 0;
  logic [DW-1:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (inst_valid) got_inst_n++;
      if (data_valid) got_data_n++;
      if (bus_error)  got_err_n++;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, ":inst_valid"}, 64'(inst_valid), 64'd0);
    check({tag, ":inst"}, 64'(inst), 64'd0);
    check({tag, ":data_valid"}, 64'(data_valid), 64'd0);
    check({tag, ":rdata"}, 64'(rdata), 64'd0);
    check({tag, ":bus_error"}, 64'(bus_error), 64'd0);
    check({tag, ":ir_ctl"}, 64'({bus.ir_addr_valid, bus.ir_data_ready}), 64'd0);
    check({tag, ":dr_ctl"}, 64'({bus.dr_addr_valid, bus.dr_data_ready}), 64'd0);
    check({tag, ":dw_ctl"}, 64'({bus.dw_data_addr_valid, bus.dw_resp_ready}), 64'd0);
    check({tag, ":addrs"}, 64'(bus.ir_addr | bus.dr_addr | bus.dw_addr), 64'd0);
    check({tag, ":dw_data"}, 64'({bus.dw_data, bus.dw_strobe}), 64'd0);
  endtask

  // Fetch: a_dly cycles of valid before ready (0 = ready already high before
  // the request), r_dly cycles of response ready before data valid.
  task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] w,
                          input int a_dly, input int r_dly);
    if (a_dly == 0) bus.ir_addr_ready = 1'b1;
    inst_fetch = 1'b1; pc = a;
    @(negedge clk);
    inst_fetch = 1'b0; pc = $urandom;
    for (int i = 0; i <= a_dly; i++) begin
      check("ir_addr_valid", 64'(bus.ir_addr_valid), 64'd1);
      check("ir_addr", 64'(bus.ir_addr), 64'(a));
      if (i == a_dly) bus.ir_addr_ready = 1'b1;
      @(negedge clk);
    end
    bus.ir_addr_ready = 1'b0;
    check("ir_addr_valid_drop", 64'(bus.ir_addr_valid), 64'd0);
    for (int i = 0; i <= r_dly; i++) begin
      check("ir_data_ready", 64'(bus.ir_data_ready), 64'd1);
      check("inst_valid_early", 64'(inst_valid), 64'd0);
      if (i == r_dly) begin bus.ir_data_valid = 1'b1; bus.ir_data = w; end
      else bus.ir_data = $urandom;
      @(negedge clk);
    end
    bus.ir_data_valid = 1'b0; bus.ir_data = $urandom;
    exp_inst_n++;
    check("inst_valid", 64'(inst_valid), 64'd1);
    check("inst", 64'(inst), 64'(w));
    check("ir_data_ready_drop", 64'(bus.ir_data_ready), 64'd0);
    check("ir_addr_hold", 64'(bus.ir_addr), 64'(a));
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] w,
                         input int a_dly, input int r_dly);
    if (a_dly == 0) bus.dr_addr_ready = 1'b1;
    load_data = 1'b1; data_addr = a;
    @(negedge clk);
    load_data = 1'b0; data_addr = $urandom;
    for (int i = 0; i <= a_dly; i++) begin
      check("dr_addr_valid", 64'(bus.dr_addr_valid), 64'd1);
      check("dr_addr", 64'(bus.dr_addr), 64'(a));
      check("dw_quiet_on_load", 64'(bus.dw_data_addr_valid), 64'd0);
      if (i == a_dly) bus.dr_addr_ready = 1'b1;
      @(negedge clk);
    end
    bus.dr_addr_ready = 1'b0;
    check("dr_addr_valid_drop", 64'(bus.dr_addr_valid), 64'd0);
    for (int i = 0; i <= r_dly; i++) begin
      check("dr_data_ready", 64'(bus.dr_data_ready), 64'd1);
      check("ld_data_valid_early", 64'(data_valid), 64'd0);
      if (i == r_dly) begin bus.dr_data_valid = 1'b1; bus.dr_data = w; end
      else bus.dr_data = $urandom;
      @(negedge clk);
    end
    bus.dr_data_valid = 1'b0; bus.dr_data = $urandom;
    exp_data_n++;
    exp_rdata = w;
    check("ld_data_valid", 64'(data_valid), 64'd1);
    check("ld_rdata", 64'(rdata), 64'(exp_rdata));
    check("ld_bus_error", 64'(bus_error), 64'd0);
    check("dr_data_ready_drop", 64'(bus.dr_data_ready), 64'd0);
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [BUS_RESP_WIDTH-1:0] r,
                          input int a_dly, input int r_dly, input bit with_load);
    if (a_dly == 0) bus.dw_data_addr_ready = 1'b1;
    store_data = 1'b1; load_data = with_load;
    data_addr = a; data_wdata = d; data_wstrb = s;
    @(negedge clk);
    store_data = 1'b0; load_data = 1'b0;
    data_addr = $urandom; data_wdata = $urandom; data_wstrb = SW'($urandom);
    for (int i = 0; i <= a_dly; i++) begin
      check("dw_valid", 64'(bus.dw_data_addr_valid), 64'd1);
      check("dw_addr", 64'(bus.dw_addr), 64'(a));
      check("dw_data", 64'(bus.dw_data), 64'(d));
      check("dw_strobe", 64'(bus.dw_strobe), 64'(s));
      check("dr_quiet_on_store", 64'(bus.dr_addr_valid), 64'd0);
      if (i == a_dly) bus.dw_data_addr_ready = 1'b1;
      @(negedge clk);
    end
    bus.dw_data_addr_ready = 1'b0;
    check("dw_valid_drop", 64'(bus.dw_data_addr_valid), 64'd0);
    for (int i = 0; i <= r_dly; i++) begin
      check("dw_resp_ready", 64'(bus.dw_resp_ready), 64'd1);
      check("st_data_valid_early", 64'(data_valid), 64'd0);
      check("dr_quiet_in_resp", 64'(bus.dr_addr_valid | bus.dr_data_ready), 64'd0);
      if (i == r_dly) begin bus.dw_resp_valid = 1'b1; bus.dw_resp = r; end
      else bus.dw_resp = BUS_RESP_WIDTH'($urandom);
      @(negedge clk);
    end
    bus.dw_resp_valid = 1'b0; bus.dw_resp = BUS_RESP_WIDTH'($urandom);
    exp_data_n++;
    if (r != BUS_RESP_OK) exp_err_n++;
    check("st_data_valid", 64'(data_valid), 64'd1);
    check("st_bus_error", 64'(bus_error), 64'(r != BUS_RESP_OK));
    check("st_rdata_kept", 64'(rdata), 64'(exp_rdata));
    check("dw_resp_ready_drop", 64'(bus.dw_resp_ready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] w, d;
    logic [SW-1:0] s;
    logic [BUS_RESP_WIDTH-1:0] r;
    int op, ad, rd, ad2, rd2;
    bit wl, use_load;

    bus.ir_addr_ready = 1'b0; bus.ir_data_valid = 1'b0; bus.ir_data = '0;
    bus.dr_addr_ready = 1'b0; bus.dr_data_valid = 1'b0; bus.dr_data = '0;
    bus.dw_data_addr_ready = 1'b0; bus.dw_resp_valid = 1'b0; bus.dw_resp = BUS_RESP_OK;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // Fetch with address ready already high and immediate response: 3-cycle latency
    do_fetch(32'h0000_0100, 32'h0050_0093, 0, 0);
    // Load with address ready held off for 4 cycles
    do_load(32'h0000_2000, 32'hDEAD_BEEF, 4, 0);
    // Store OK, then store with error response
    do_store(32'h0000_3000, 32'h1234_5678, 4'hF, BUS_RESP_OK, 2, 1, 1'b0);
    do_store(32'h0000_3004, 32'hCAFE_F00D, 4'h3, BUS_RESP_ERROR, 0, 0, 1'b0);

    // Simultaneous load+store (store wins) while a fetch runs, plus a fetch
    // request arriving while the fetch FSM is busy
    fork
      do_store(32'h0000_4000, 32'hA5A5_5A5A, 4'hC, BUS_RESP_OK, 1, 2, 1'b1);
      do_fetch(32'h0000_0200, 32'h1111_2222, 1, 2);
      begin
        repeat (2) @(negedge clk);
        inst_fetch = 1'b1; pc = 32'h0000_BAD0;
        @(negedge clk);
        inst_fetch = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check("no_extra_fetch", 64'(bus.ir_addr_valid), 64'd0);
    check("no_dropped_load", 64'(bus.dr_addr_valid), 64'd0);

    // Randomized mix, including overlapping instruction and data traffic
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      a = $urandom; w = $urandom; d = $urandom; s = SW'($urandom);
      r = BUS_RESP_WIDTH'($urandom_range(0, 1));
      ad = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      ad2 = $urandom_range(0, 3); rd2 = $urandom_range(0, 3);
      wl = 1'($urandom_range(0, 1)); use_load = 1'($urandom_range(0, 1));
      case (op)
        0: do_fetch(a, w, ad, rd);
        1: do_load(a, w, ad, rd);
        2: do_store(a, d, s, r, ad, rd, wl);
        default: fork
          do_fetch(a, w, ad, rd);
          begin
            if (use_load) do_load(~a, d, ad2, rd2);
            else          do_store(~a, d, s, r, ad2, rd2, wl);
          end
        join
      endcase
    end

    // Reset while the data FSM waits for the read response; a late response
    // must be ignored
    do_load(32'h0000_5000, 32'h7777_8888, 1, 0);
    load_data = 1'b1; data_addr = 32'h0000_6000;
    @(negedge clk);
    load_data = 1'b0;
    bus.dr_addr_ready = 1'b1;
    @(negedge clk);
    bus.dr_addr_ready = 1'b0;
    check("pre_rst_dr_data_ready", 64'(bus.dr_data_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    exp_rdata = '0;
    check_reset_values("mid_rst");
    rst = 1'b1;
    bus.dr_data_valid = 1'b1; bus.dr_data = 32'h9999_AAAA;
    @(negedge clk);
    bus.dr_data_valid = 1'b0;
    check("late_resp_ready", 64'(bus.dr_data_ready), 64'd0);
    check("late_resp_no_pulse", 64'(data_valid), 64'd0);
    check("late_resp_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    check("late_resp_no_pulse2", 64'(data_valid), 64'd0);

    // Recovery after reset
    do_load(32'h0000_7000, 32'h0BAD_CAFE, 0, 1);
    do_fetch(32'h0000_0300, 32'h0000_0013, 2, 0);

    repeat (3) @(negedge clk);
    check("inst_pulse_count", 64'(got_inst_n), 64'(exp_inst_n));
    check("data_pulse_count", 64'(got_data_n), 64'(exp_data_n));
    check("error_pulse_count", 64'(got_err_n), 64'(exp_err_n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
